// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback vs. buffered
// long-latency results, with anti-starvation forced drain.
module rf_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int REG_W        = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wb_valid,
    input  logic [REG_W-1:0]           wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    output logic                       wb_stall,
    input  logic                       ll_valid,
    output logic                       ll_ready,
    input  logic [REG_W-1:0]           ll_addr,
    input  logic [DATA_W-1:0]          ll_data,
    input  logic [REG_W-1:0]           query_addr,
    output logic                       query_hit,
    output logic                       rw_en,
    output logic [REG_W-1:0]           rw_addr,
    output logic [DATA_W-1:0]          rw_data,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [REG_W-1:0] R0       = '0;

    logic [REG_W-1:0]  ent_addr_q [DEPTH];
    logic [REG_W-1:0]  ent_addr_d [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    logic [DEPTH-1:0]  ent_vld_q;
    logic [DEPTH-1:0]  ent_vld_d;

    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [SC_W-1:0]   starve_q;
    logic [SC_W-1:0]   starve_d;

    logic              rw_en_q;
    logic              rw_en_d;
    logic [REG_W-1:0]  rw_addr_q;
    logic [REG_W-1:0]  rw_addr_d;
    logic [DATA_W-1:0] rw_data_q;
    logic [DATA_W-1:0] rw_data_d;

    logic              empty;
    logic              full;
    logic              push;
    logic              fifo_gnt;
    logic              wb_gnt;
    logic [REG_W-1:0]  head_addr;
    logic [DATA_W-1:0] head_data;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_FULL);
    assign ll_ready  = !full;
    assign push      = ll_valid && !full;
    assign head_addr = ent_addr_q[rd_ptr_q];
    assign head_data = ent_data_q[rd_ptr_q];

    // Head wins when writeback is idle or the head has waited long enough.
    assign fifo_gnt  = !empty && (!wb_valid || (starve_q == SC_MAX));
    assign wb_gnt    = wb_valid && !fifo_gnt;
    assign wb_stall  = wb_valid && fifo_gnt;

    assign rw_en      = rw_en_q;
    assign rw_addr    = rw_addr_q;
    assign rw_data    = rw_data_q;
    assign fifo_count = count_q;

    always_comb begin
        query_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld_q[i] && (ent_addr_q[i] == query_addr)) begin
                query_hit = 1'b1;
            end
        end
        if (query_addr == R0) begin
            query_hit = 1'b0;
        end
    end

    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_data_d = ent_data_q;
        ent_vld_d  = ent_vld_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (fifo_gnt) begin
            ent_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d            = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            ent_addr_d[wr_ptr_q] = ll_addr;
            ent_data_d[wr_ptr_q] = ll_data;
            ent_vld_d[wr_ptr_q]  = 1'b1;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        unique case ({push, fifo_gnt})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (empty || fifo_gnt) begin
            starve_d = '0;
        end else if (starve_q != SC_MAX) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    // r0 writes still take the grant but never assert the enable.
    always_comb begin
        rw_en_d   = 1'b0;
        rw_addr_d = rw_addr_q;
        rw_data_d = rw_data_q;
        if (fifo_gnt) begin
            rw_en_d   = (head_addr != R0);
            rw_addr_d = head_addr;
            rw_data_d = head_data;
        end else if (wb_gnt) begin
            rw_en_d   = (wb_addr != R0);
            rw_addr_d = wb_addr;
            rw_data_d = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_data_q[i] <= '0;
            end
            ent_vld_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            rw_en_q   <= 1'b0;
            rw_addr_q <= '0;
            rw_data_q <= '0;
        end else begin
            ent_addr_q <= ent_addr_d;
            ent_data_q <= ent_data_d;
            ent_vld_q  <= ent_vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            rw_en_q    <= rw_en_d;
            rw_addr_q  <= rw_addr_d;
            rw_data_q  <= rw_data_d;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed-vector bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_addr;
    logic [31:0] ll_data;
    logic [4:0]  query_addr;
    logic        query_hit;
    logic        rw_en;
    logic [4:0]  rw_addr;
    logic [31:0] rw_data;
    logic [2:0]  fifo_count;

    int vec_cnt;
    int err_cnt;

    rf_wb_arbiter #(
        .DATA_W(32), .REG_W(5), .DEPTH(4), .STARVE_LIMIT(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_stall(wb_stall),
        .ll_valid(ll_valid), .ll_ready(ll_ready),
        .ll_addr(ll_addr), .ll_data(ll_data),
        .query_addr(query_addr), .query_hit(query_hit),
        .rw_en(rw_en), .rw_addr(rw_addr), .rw_data(rw_data),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  exp_a [5];
    logic [31:0] exp_d [5];

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        ll_valid = 1'b0; ll_addr = '0; ll_data = '0;
        query_addr = '0;
        #12;
        chk("rst_rw_en", 64'(rw_en), 64'd0);
        chk("rst_rw_addr", 64'(rw_addr), 64'd0);
        chk("rst_rw_data", 64'(rw_data), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        chk("rst_ll_ready", 64'(ll_ready), 64'd1);
        chk("rst_wb_stall", 64'(wb_stall), 64'd0);
        chk("rst_query_hit", 64'(query_hit), 64'd0);
        rst_n = 1'b1;
        tick();

        // plain writeback
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234;
        #1;
        chk("wb_stall_t1", 64'(wb_stall), 64'd0);
        tick();
        chk("wb_en", 64'(rw_en), 64'd1);
        chk("wb_addr", 64'(rw_addr), 64'd5);
        chk("wb_data", 64'(rw_data), 64'h1234);
        chk("wb_stall_t1b", 64'(wb_stall), 64'd0);
        wb_valid = 1'b0;
        tick();
        chk("idle_en", 64'(rw_en), 64'd0);
        chk("idle_hold_addr", 64'(rw_addr), 64'd5);
        chk("idle_hold_data", 64'(rw_data), 64'h1234);

        // single long-latency push with idle writeback
        ll_valid = 1'b1; ll_addr = 5'd7; ll_data = 32'hDEAD;
        query_addr = 5'd7;
        #1;
        chk("qhit_before", 64'(query_hit), 64'd0);
        tick();
        ll_valid = 1'b0;
        #1;
        chk("ll1_count", 64'(fifo_count), 64'd1);
        chk("ll1_qhit", 64'(query_hit), 64'd1);
        chk("ll1_nobypass", 64'(rw_en), 64'd0);
        tick();
        chk("ll1_en", 64'(rw_en), 64'd1);
        chk("ll1_addr", 64'(rw_addr), 64'd7);
        chk("ll1_data", 64'(rw_data), 64'hDEAD);
        chk("ll1_count0", 64'(fifo_count), 64'd0);
        chk("ll1_qhit0", 64'(query_hit), 64'd0);

        // starvation: head forced after STARVE_LIMIT denials
        wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'h3333;
        ll_valid = 1'b1; ll_addr = 5'd9; ll_data = 32'hBEEF;
        tick();
        ll_valid = 1'b0;
        chk("st_first_addr", 64'(rw_addr), 64'd3);
        chk("st_count", 64'(fifo_count), 64'd1);
        for (int i = 1; i <= 3; i++) begin
            #1;
            chk($sformatf("st_nostall%0d", i), 64'(wb_stall), 64'd0);
            tick();
            chk($sformatf("st_wb%0d", i), 64'(rw_addr), 64'd3);
            chk($sformatf("st_en%0d", i), 64'(rw_en), 64'd1);
        end
        #1;
        chk("st_stall", 64'(wb_stall), 64'd1);
        tick();
        chk("st_forced_addr", 64'(rw_addr), 64'd9);
        chk("st_forced_data", 64'(rw_data), 64'hBEEF);
        chk("st_count0", 64'(fifo_count), 64'd0);
        chk("st_resume_stall", 64'(wb_stall), 64'd0);
        tick();
        chk("st_resume_addr", 64'(rw_addr), 64'd3);
        chk("st_resume_data", 64'(rw_data), 64'h3333);
        wb_valid = 1'b0;
        tick();

        // fill to full with writeback busy, then drain in order
        wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444;
        for (int i = 0; i < 4; i++) begin
            exp_a[i] = 5'(10 + i);
            exp_d[i] = 32'hA000 + 32'(i);
            ll_valid = 1'b1; ll_addr = exp_a[i]; ll_data = exp_d[i];
            tick();
            chk($sformatf("fill_count%0d", i), 64'(fifo_count), 64'(i + 1));
        end
        exp_a[4] = 5'd14;
        exp_d[4] = 32'hA004;
        ll_addr = exp_a[4]; ll_data = exp_d[4];
        #1;
        chk("full_ready", 64'(ll_ready), 64'd0);
        chk("full_stall", 64'(wb_stall), 64'd1);
        tick();
        chk("full_pop_addr", 64'(rw_addr), 64'(exp_a[0]));
        chk("full_pop_data", 64'(rw_data), 64'(exp_d[0]));
        chk("full_nopush", 64'(fifo_count), 64'd3);
        chk("full_ready1", 64'(ll_ready), 64'd1);
        tick();
        chk("push5_count", 64'(fifo_count), 64'd4);
        chk("push5_wb", 64'(rw_addr), 64'd4);
        ll_valid = 1'b0;
        wb_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            tick();
            chk($sformatf("drain_addr%0d", i), 64'(rw_addr), 64'(exp_a[i]));
            chk($sformatf("drain_data%0d", i), 64'(rw_data), 64'(exp_d[i]));
            chk($sformatf("drain_cnt%0d", i), 64'(fifo_count), 64'(4 - i));
        end

        // r0 targets
        wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h5555;
        tick();
        chk("r0_wb_en", 64'(rw_en), 64'd0);
        wb_valid = 1'b0;
        ll_valid = 1'b1; ll_addr = 5'd0; ll_data = 32'h6666;
        query_addr = 5'd0;
        tick();
        ll_valid = 1'b0;
        chk("r0_ll_count", 64'(fifo_count), 64'd1);
        chk("r0_qhit", 64'(query_hit), 64'd0);
        tick();
        chk("r0_ll_en", 64'(rw_en), 64'd0);
        chk("r0_ll_popped", 64'(fifo_count), 64'd0);

        // reset with entries buffered
        wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h7777;
        for (int i = 0; i < 3; i++) begin
            ll_valid = 1'b1; ll_addr = 5'(20 + i); ll_data = 32'hC000 + 32'(i);
            tick();
        end
        ll_valid = 1'b0;
        wb_valid = 1'b0;
        query_addr = 5'd20;
        #1;
        chk("pre_rst_count", 64'(fifo_count), 64'd3);
        chk("pre_rst_en", 64'(rw_en), 64'd1);
        chk("pre_rst_qhit", 64'(query_hit), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(fifo_count), 64'd0);
        chk("mid_rst_en", 64'(rw_en), 64'd0);
        chk("mid_rst_qhit", 64'(query_hit), 64'd0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("post_rst_en%0d", i), 64'(rw_en), 64'd0);
            chk($sformatf("post_rst_cnt%0d", i), 64'(fifo_count), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the single register-file write port between the in-order writeback stage and long-latency result producers (divider, multi-cycle multiplier), which return results out of pipeline order. Long-latency results are buffered in a small FIFO and drained into the write port. Writeback normally has priority; an anti-starvation counter forces a FIFO drain and stalls writeback for that cycle. The block sits between the writeback stage and the register file. It also drives the debug write-back signals and provides an interlock query for decode.

## Interface
Parameters:
- DATA_W, 32, register data width
- REG_W, 5, register index width
- DEPTH, 4, FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 3, cycles a non-empty FIFO head may be denied before it is forced

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- wb_valid  in  1  writeback stage requests a register write this cycle
- wb_addr  in  REG_W  writeback destination register
- wb_data  in  DATA_W  writeback data
- wb_stall  out  1  combinational; writeback denied this cycle and must hold its request
- ll_valid  in  1  long-latency unit offers a result
- ll_ready  out  1  FIFO can accept a result; `ll_ready = !full`
- ll_addr  in  REG_W  long-latency destination register
- ll_data  in  DATA_W  long-latency result
- query_addr  in  REG_W  decode source register to check
- query_hit  out  1  combinational; a buffered FIFO entry targets query_addr (never set for r0)
- rw_en  out  1  registered register-file write enable
- rw_addr  out  REG_W  registered write address
- rw_data  out  DATA_W  registered write data
- fifo_count  out  $clog2(DEPTH)+1  buffered entry count

## Operation
- Push: on `ll_valid && ll_ready`, append {ll_addr, ll_data} at the tail.
- Grant, evaluated each cycle:
  - FIFO empty: writeback wins whenever wb_valid.
  - FIFO non-empty and (!wb_valid or starve_cnt == STARVE_LIMIT): FIFO head wins and is popped. wb_stall = wb_valid.
  - Otherwise: writeback wins and wb_stall = 0.
- starve_cnt (width fits STARVE_LIMIT):
  - cleared when the FIFO is empty or the head is granted;
  - incremented (saturating) each cycle the head is denied.
- Winner is latched next edge into rw_en/rw_addr/rw_data.
  - rw_en = 1 only if the winning address ≠ 0. Writes to r0 still consume the grant and pop, but produce rw_en = 0.
  - No grant: rw_en = 0 and rw_addr/rw_data hold their previous values.
- Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- No bypass: a result pushed into an empty FIFO is drained no earlier than the next cycle.
- query_hit: OR over valid entries of (entry_addr == query_addr), with query_addr ≠ 0. The output-register stage is not included; the register file forwards it.
- Debug write-back outputs mirror rw_en/rw_addr/rw_data. Debug pc comes from the writeback stage and is not part of this block.

## Timing
- Reset (async assert, sync release): FIFO empty, fifo_count = 0, starve_cnt = 0, rw_en = 0, rw_addr = 0, rw_data = 0. Combinational outputs then evaluate to ll_ready = 1, wb_stall = 0, query_hit = 0.
- Reset asserted mid-operation discards all buffered entries; nothing is written after release.
- Latency:
  - writeback request to rw_en: 1 cycle;
  - long-latency push to rw_en: ≥2 cycles.
- ll_ready is combinational from the registered count only. A push into a full FIFO is not possible even when a pop happens in the same cycle.
- wb_stall depends on wb_valid, FIFO empty and starve_cnt. It never depends on ll_valid.
- Forced drain: with wb_valid held high continuously, a non-empty FIFO head is granted at most STARVE_LIMIT+1 cycles after it reaches the head.

## Test plan
- Reset, then wb_valid=1, addr 5, data 0x1234 → next cycle rw_en=1, rw_addr=5, rw_data=0x1234. wb_stall stays 0 throughout.
- FIFO empty, wb idle, ll push {7, 0xDEAD} → fifo_count=1 for one cycle, then rw_en=1 with {7, 0xDEAD} two cycles after the push. query_hit=1 for query_addr=7 while the entry is buffered.
- wb_valid held high (addr 3) and one ll push {9, 0xBEEF}, STARVE_LIMIT=3 → 3 writeback grants, then on the 4th cycle wb_stall=1 and {9, 0xBEEF} is written. Writeback resumes the following cycle and the stalled write is not lost.
- 4 back-to-back pushes with wb_valid high → ll_ready=0 at count 4. A 5th ll_valid is held and accepted only after a pop. Entries drain in push order and fifo_count returns to 0.
- Writes targeting r0 (from both writeback and FIFO) → rw_en=0, and the FIFO entry is still popped.
- rst_n pulsed low with 3 entries buffered → fifo_count=0 and rw_en=0 immediately. No writes occur after release.
